dmem_responder: RTL
===================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 256, meaning number of 32-bit words stored.
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, meaning wait states inserted per access when DMEM_WAIT_EN is defined.
REQ-003 SHALL have port clk, input, 1 bit, the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit, reset that is synchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit, core presents a memory request.
REQ-006 SHALL have port req_ready, output, 1 bit, responder can accept a request this cycle.
REQ-007 SHALL have port memread, input, 1 bit, request is a load.
REQ-008 SHALL have port memwrite, input, 1 bit, request is a store.
REQ-009 SHALL have port addr, input, 32 bits, byte address; aluout from the core.
REQ-010 SHALL have port wdata, input, 32 bits, store data; read_data_2 from the core.
REQ-011 SHALL have port rdata, output, 32 bits, load data returned.
REQ-012 SHALL have port resp_valid, output, 1 bit, one-cycle response strobe.
REQ-013 SHALL have port resp_err, output, 1 bit, qualifies resp_valid; access was rejected.
REQ-014 SHALL have port busy, output, 1 bit, a request is outstanding.

Function
REQ-015 SHALL implement FSM states IDLE, WAIT, RESP; one request outstanding at most.
REQ-016 SHALL assert req_ready only in IDLE; accept on a rising edge with req_valid && req_ready && (memread || memwrite).
REQ-017 SHALL ignore req_valid with memread=memwrite=0; state stays IDLE.
REQ-018 SHALL latch addr, wdata, memread, memwrite at acceptance; later input changes do not affect the access.
REQ-019 SHALL flag error when memread && memwrite, addr[1:0] != 0, or addr[31:2] >= DEPTH_WORDS.
REQ-020 SHALL never modify storage on an errored access; errored load returns rdata = 32'h0.
REQ-021 SHALL commit a store on the edge entering RESP; a load samples storage on that same edge into rdata.
REQ-022 SHALL assert resp_valid for exactly one cycle in RESP, then return to IDLE; resp_err valid only with resp_valid.
REQ-023 SHALL hold rdata stable from the RESP cycle until the next load response; stores leave rdata unchanged.
REQ-024 SHALL assert busy in WAIT and RESP, deassert in IDLE.
REQ-025 SHALL index storage by addr[31:2], word granularity only; no byte enables.

Reset
REQ-026 SHALL, on rst high at a clock edge, force IDLE, req_ready=1 on the following cycle, resp_valid=0, resp_err=0, rdata=0, busy=0.
REQ-027 SHALL abort an outstanding access on reset; a store not yet committed is discarded; storage contents are not cleared.
REQ-028 SHALL give rst priority over a simultaneous request acceptance.

Configuration
REQ-029 SHALL, with DMEM_WAIT_EN defined, transition IDLE->WAIT and count WAIT_CYCLES cycles before RESP: resp_valid 1+WAIT_CYCLES cycles after acceptance; WAIT_CYCLES=0 skips WAIT.
REQ-030 SHALL, without DMEM_WAIT_EN, go IDLE->RESP directly: resp_valid the cycle after acceptance; no counter logic present.

Structure
REQ-031 SHALL take DATA_W=32, ADDR_W=32 and the FSM state enumeration from shared package mips_pkg.
REQ-032 SHALL place storage in sub-module dmem_array (synchronous write, registered read, word-indexed); FSM, checks and counter stay in dmem_responder.

Verification
REQ-033 Store 32'hDEADBEEF to 0x10, then load 0x10 -> store resp_valid with resp_err=0; load rdata=32'hDEADBEEF.
REQ-034 Load from 0x13 (misaligned) -> resp_err=1, rdata=0; a later load of 0x10 still returns 32'hDEADBEEF.
REQ-035 Store to 0x400 with DEPTH_WORDS=256 -> resp_err=1; storage unchanged.
REQ-036 With DMEM_WAIT_EN and WAIT_CYCLES=2, hold req_valid high -> req_ready low for 3 cycles after acceptance; resp_valid exactly 3 cycles after the accept edge; second request accepted only after return to IDLE.
REQ-037 Assert rst during WAIT of store 32'h12345678 to 0x20 -> resp_valid never asserts; a later load of 0x20 returns the prior contents.
REQ-038 memread=memwrite=1 to 0x08 -> resp_err=1, word 0x08 unchanged; req_valid with both low -> no acceptance, busy stays 0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the data-memory path: bus widths, responder FSM states
// and the access legality check.
package mips_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  // Rejected accesses: load and store at once, misaligned word, or beyond the array.
  function automatic logic access_err(
    input logic              rd,
    input logic              wr,
    input logic [ADDR_W-1:0] a,
    input int unsigned       depth
  );
    return (rd && wr) || (a[1:0] != 2'b00) || ({2'b00, a[ADDR_W-1:2]} >= depth);
  endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-indexed data storage: synchronous write, registered read that holds its
// value between read enables.
module dmem_array
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int IDX_W       = 8
) (
  input  logic              clk,
  input  logic              we,
  input  logic              re,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH_WORDS];

  // NOTE: the storage array and its read register are deliberately not reset;
  // contents must survive reset, and a resettable array would not map to RAM.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
    if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with req/resp handshake and error checks.
// Define DMEM_WAIT_EN to insert WAIT_CYCLES wait states between acceptance and response.
module dmem_responder
  import mips_pkg::*;
#(
  parameter int DEPTH_WORDS = 256,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              memread,
  input  logic              memwrite,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic              busy
);

  localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

  dmem_state_e       state, state_next;
  logic              accept;
  logic              enter_resp;
  logic              live_err;
  logic              acc_rd, acc_wr, acc_err;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic              mem_we, mem_re;
  logic [DATA_W-1:0] mem_rdata;
  logic              err_q;
  logic              rdata_zero;

  assign req_ready = (state == IDLE);
  assign accept    = req_ready && req_valid && (memread || memwrite);
  assign live_err  = access_err(memread, memwrite, addr, DEPTH_WORDS);

`ifdef DMEM_WAIT_EN
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  logic [CNT_W-1:0]  wait_cnt;
  logic              cnt_done;
  logic              lat_rd, lat_wr, lat_err;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;

  assign cnt_done = (wait_cnt == CNT_W'(WAIT_CYCLES - 1));

  // Request fields are frozen at acceptance; only consumed once the FSM leaves IDLE.
  always_ff @(posedge clk) begin
    if (accept) begin
      lat_rd    <= memread;
      lat_wr    <= memwrite;
      lat_err   <= live_err;
      lat_addr  <= addr;
      lat_wdata <= wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)                 wait_cnt <= '0;
    else if (accept)         wait_cnt <= '0;
    else if (state == WAIT)  wait_cnt <= wait_cnt + 1'b1;
  end

  assign acc_rd     = (state == IDLE) ? memread  : lat_rd;
  assign acc_wr     = (state == IDLE) ? memwrite : lat_wr;
  assign acc_err    = (state == IDLE) ? live_err : lat_err;
  assign acc_addr   = (state == IDLE) ? addr     : lat_addr;
  assign acc_wdata  = (state == IDLE) ? wdata    : lat_wdata;
  assign enter_resp = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && cnt_done);
`else
  assign acc_rd     = memread;
  assign acc_wr     = memwrite;
  assign acc_err    = live_err;
  assign acc_addr   = addr;
  assign acc_wdata  = wdata;
  assign enter_resp = accept;
`endif

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE: begin
        if (accept) begin
`ifdef DMEM_WAIT_EN
          state_next = (WAIT_CYCLES == 0) ? RESP : WAIT;
`else
          state_next = RESP;
`endif
        end
      end
`ifdef DMEM_WAIT_EN
      WAIT:    if (cnt_done) state_next = RESP;
`else
      WAIT:    state_next = IDLE;
`endif
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Reset gates the commit so a store racing a reset is dropped.
  assign mem_we = enter_resp && !rst && acc_wr && !acc_err;
  assign mem_re = enter_resp && !rst && acc_rd && !acc_err;

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .IDX_W       (IDX_W)
  ) u_array (
    .clk   (clk),
    .we    (mem_we),
    .re    (mem_re),
    .idx   (acc_addr[IDX_W+1:2]),
    .wdata (acc_wdata),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      err_q      <= 1'b0;
      rdata_zero <= 1'b1;
    end else begin
      state <= state_next;
      if (enter_resp) begin
        err_q <= acc_err;
        if (acc_rd) rdata_zero <= acc_err;
      end
    end
  end

  // rdata_zero masks the array read register after reset and after a rejected load.
  assign rdata      = rdata_zero ? '0 : mem_rdata;
  assign resp_valid = (state == RESP);
  assign resp_err   = resp_valid && err_q;
  assign busy       = (state != IDLE);

endmodule
